// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one single-outstanding cache port among NUM_REQ requesters.
// Grant to cache pulse: 1 cycle; occupancy = cache latency + 2; req_valid_in is ignored while a transaction is in WAIT.
module cache_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic [NUM_REQ-1:0]            resp_valid_out,
    output logic [DATA_WIDTH-1:0]         resp_data_out,
    output logic                          resp_err_out,
    output logic [ADDR_WIDTH-1:0]         cache_addr_out,
    output logic                          cache_addr_valid_out,
    input  logic [DATA_WIDTH-1:0]         cache_val_in,
    input  logic                          cache_valid_in,
    output logic                          busy_out,
    output logic [$clog2(NUM_REQ)-1:0]    owner_out
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_gnt_vld;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_next_ptr;
    logic [NUM_REQ-1:0] w_owner_oh;

    // Scan from the highest offset down so the closest set bit to r_rr_ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
            if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
            end
            if (req_valid_in[w_sum[ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_next_ptr = (owner_out == ID_W'(NUM_REQ - 1)) ? '0 : owner_out + ID_W'(1);
    assign w_owner_oh = NUM_REQ'(1) << owner_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state              <= ST_IDLE;
            r_rr_ptr             <= '0;
            r_cnt                <= '0;
            req_ready_out        <= '0;
            resp_valid_out       <= '0;
            resp_data_out        <= '0;
            resp_err_out         <= 1'b0;
            cache_addr_out       <= '0;
            cache_addr_valid_out <= 1'b0;
            busy_out             <= 1'b0;
            owner_out            <= '0;
        end else begin
            req_ready_out        <= '0;
            cache_addr_valid_out <= 1'b0;
            resp_valid_out       <= '0;
            resp_err_out         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        req_ready_out        <= NUM_REQ'(1) << w_gnt_id;
                        cache_addr_out       <= req_addr_in[int'(w_gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
                        cache_addr_valid_out <= 1'b1;
                        owner_out            <= w_gnt_id;
                        busy_out             <= 1'b1;
                        r_cnt                <= '0;
                        r_state              <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A real answer on the timeout cycle takes priority over the error.
                    if (cache_valid_in) begin
                        resp_data_out  <= cache_val_in;
                        resp_valid_out <= w_owner_oh;
                        r_rr_ptr       <= w_next_ptr;
                        busy_out       <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_data_out  <= '0;
                        resp_valid_out <= w_owner_oh;
                        resp_err_out   <= 1'b1;
                        r_rr_ptr       <= w_next_ptr;
                        busy_out       <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a latency-programmable cache model and grant/response scoreboards.
module tb_cache_arbiter;
    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          gap;
    } rsp_t;

    logic         clk_in;
    logic         rst_n_in;
    logic [3:0]   req_valid_in;
    logic [127:0] req_addr_in;
    logic [3:0]   req_ready_out;
    logic [3:0]   resp_valid_out;
    logic [31:0]  resp_data_out;
    logic         resp_err_out;
    logic [31:0]  cache_addr_out;
    logic         cache_addr_valid_out;
    logic [31:0]  cache_val_in;
    logic         cache_valid_in;
    logic         busy_out;
    logic [1:0]   owner_out;

    logic [31:0]  addrs [4];
    int           need [4];
    int           exp_gnt [$];
    rsp_t         exp_rsp [$];

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           pulse_cyc = 0;
    bit           pend = 0;
    int           cd = 0;
    logic [31:0]  pend_addr = '0;
    bit           silent = 0;
    int           lat = 1;
    bit           fix_en = 0;
    logic [31:0]  fix_dat = '0;

    cache_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in), .req_addr_in(req_addr_in),
        .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out),
        .resp_data_out(resp_data_out), .resp_err_out(resp_err_out),
        .cache_addr_out(cache_addr_out), .cache_addr_valid_out(cache_addr_valid_out),
        .cache_val_in(cache_val_in), .cache_valid_in(cache_valid_in),
        .busy_out(busy_out), .owner_out(owner_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always_comb begin
        for (int i = 0; i < 4; i++) req_addr_in[i*32 +: 32] = addrs[i];
    end

    function automatic logic [31:0] cache_word(input logic [31:0] a);
        return a ^ 32'hDEAD_ACDB;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic all_outs();
        return |{req_ready_out, resp_valid_out, resp_data_out, resp_err_out,
                 cache_addr_out, cache_addr_valid_out, busy_out, owner_out};
    endfunction

    task automatic push_rsp(input int id, input logic [31:0] data, input logic err, input int gap);
        rsp_t e;
        e.id = id; e.data = data; e.err = err; e.gap = gap;
        exp_rsp.push_back(e);
    endtask

    // One clock: advance the cache model, then check grants and responses seen after the edge.
    task automatic tick();
        int   g;
        rsp_t e;
        @(posedge clk_in);
        #1;
        cyc++;
        cache_valid_in = 1'b0;
        if (pend) begin
            if (cd <= 1) begin
                cache_valid_in = 1'b1;
                cache_val_in   = fix_en ? fix_dat : cache_word(pend_addr);
                pend           = 0;
            end else begin
                cd--;
            end
        end
        if (req_ready_out != 4'b0 || cache_addr_valid_out) begin
            if (exp_gnt.size() == 0) begin
                chk("unexpected_grant", {req_ready_out, cache_addr_valid_out}, 0);
            end else begin
                g = exp_gnt.pop_front();
                chk("grant_onehot", req_ready_out, 128'(1) << g);
                chk("addr_valid", cache_addr_valid_out, 1);
                chk("cache_addr", cache_addr_out, addrs[g]);
                chk("grant_owner", owner_out, g);
                chk("grant_busy", busy_out, 1);
                need[g]--;
                if (need[g] <= 0) req_valid_in[g] = 1'b0;
                pulse_cyc = cyc;
                if (!silent) begin
                    pend = 1; cd = lat; pend_addr = cache_addr_out;
                end
            end
        end
        if (resp_valid_out != 4'b0) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_resp", resp_valid_out, 0);
            end else begin
                e = exp_rsp.pop_front();
                chk("resp_onehot", resp_valid_out, 128'(1) << e.id);
                chk("resp_data", resp_data_out, e.data);
                chk("resp_err", resp_err_out, e.err);
                chk("resp_busy", busy_out, 0);
                if (e.gap >= 0) chk("resp_gap", cyc - pulse_cyc, e.gap);
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && (exp_rsp.size() > 0 || exp_gnt.size() > 0); i++) tick();
        chk({tag, "_pending"}, exp_rsp.size() + exp_gnt.size(), 0);
    endtask

    initial begin
        rst_n_in = 1'b0; req_valid_in = '0; cache_val_in = '0; cache_valid_in = 1'b0;
        addrs[0] = 32'h1000_0000; addrs[1] = 32'h2000_0040;
        addrs[2] = 32'h0000_1234; addrs[3] = 32'h3000_0ABC;
        for (int i = 0; i < 4; i++) need[i] = 0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_outputs", all_outs(), 0);
        rst_n_in = 1'b1;
        tick();
        chk("idle_outputs", all_outs(), 0);

        // All four requesters held: rotation from pointer 0.
        lat = 2;
        need[0] = 2; need[1] = 2; need[2] = 1; need[3] = 1;
        req_valid_in = 4'hF;
        foreach (need[i]) ;
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
        exp_gnt.push_back(3); exp_gnt.push_back(0); exp_gnt.push_back(1);
        push_rsp(0, cache_word(addrs[0]), 0, 3); push_rsp(1, cache_word(addrs[1]), 0, 3);
        push_rsp(2, cache_word(addrs[2]), 0, 3); push_rsp(3, cache_word(addrs[3]), 0, 3);
        push_rsp(0, cache_word(addrs[0]), 0, 3); push_rsp(1, cache_word(addrs[1]), 0, 3);
        wait_done("round_robin", 200);

        // Single requester 2, cache latency 3.
        lat = 3; need[2] = 1; req_valid_in[2] = 1'b1;
        exp_gnt.push_back(2);
        push_rsp(2, 32'hDEAD_BEEF, 0, 4);
        wait_done("single_req2", 50);

        // Silent cache: error after exactly 16 cycles, then normal service for requester 1.
        silent = 1; need[0] = 1; req_valid_in[0] = 1'b1;
        exp_gnt.push_back(0);
        push_rsp(0, 32'h0, 1, 16);
        wait_done("timeout", 60);
        silent = 0; lat = 1; need[1] = 1; req_valid_in[1] = 1'b1;
        exp_gnt.push_back(1);
        push_rsp(1, cache_word(addrs[1]), 0, 2);
        wait_done("after_timeout", 30);

        // Stray cache response while idle must be dropped.
        cache_valid_in = 1'b1; cache_val_in = 32'h0000_CAFE;
        tick();
        tick();
        chk("stray_owner", owner_out, 1);
        chk("stray_busy", busy_out, 0);

        // Cache answers on the timeout cycle: valid response wins.
        fix_en = 1; fix_dat = 32'h0000_CAFE; lat = 15;
        need[3] = 1; req_valid_in[3] = 1'b1;
        exp_gnt.push_back(3);
        push_rsp(3, 32'h0000_CAFE, 0, 16);
        wait_done("timeout_tie", 60);
        fix_en = 0;

        // Asynchronous reset in the middle of a WAIT.
        silent = 1; need[1] = 1; req_valid_in[1] = 1'b1;
        exp_gnt.push_back(1);
        wait_done("pre_reset_grant", 10);
        repeat (3) tick();
        #2;
        rst_n_in = 1'b0;
        pend = 0;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        silent = 0;
        cache_valid_in = 1'b1; cache_val_in = 32'h5555_5555;
        tick();
        tick();
        chk("late_resp_busy", busy_out, 0);
        chk("late_resp_outputs", all_outs(), 0);

        // Pointer back at 0: requester 0 beats requester 3.
        lat = 2; need[0] = 1; need[3] = 1; req_valid_in = 4'b1001;
        exp_gnt.push_back(0); exp_gnt.push_back(3);
        push_rsp(0, cache_word(addrs[0]), 0, 3);
        push_rsp(3, cache_word(addrs[3]), 0, 3);
        wait_done("post_reset_order", 60);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Round-robin arbiter and sequencer that shares the single request port of `cache` (one outstanding address, variable hit/miss latency) among `NUM_REQ` requesters. It grants one requester at a time and issues that requester's address to the cache as a one-cycle `addr_validin` pulse. It waits for `valid_out`, then routes the returned word back to the owning requester. A timeout guarantees forward progress if the cache never answers.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ADDR_WIDTH`, 32: request address width; matches cache `addr`.
- `DATA_WIDTH`, 32: response width; matches cache `val_out`.
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before an error response; ≥2.
- `ID_W`, derived as `$clog2(NUM_REQ)`: not overridable.

Ports:
- `clk_in`  in  1  single clock for the block.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `req_valid_in`  in  NUM_REQ  per-requester request; held high with its address until that requester's `req_ready_out` is seen.
- `req_addr_in`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_ready_out`  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- `resp_valid_out`  out  NUM_REQ  one-hot, one-cycle response pulse to the owner.
- `resp_data_out`  out  DATA_WIDTH  response word, valid only with `resp_valid_out`.
- `resp_err_out`  out  1  high with `resp_valid_out` when the response is a timeout.
- `cache_addr_out`  out  ADDR_WIDTH  address to `cache.addr`.
- `cache_addr_valid_out`  out  1  one-cycle pulse to `cache.addr_validin`.
- `cache_val_in`  in  DATA_WIDTH  from `cache.val_out`.
- `cache_valid_in`  in  1  from `cache.valid_out`.
- `busy_out`  out  1  high while in WAIT.
- `owner_out`  out  ID_W  index of the current or last grantee.

## Operation
- All outputs are registered.
- Reset (`rst_n_in`=0) takes effect immediately and asynchronously:
  - every output is 0;
  - state is IDLE, `rr_ptr`=0, timeout counter is 0.
- IDLE:
  - If no bit of `req_valid_in` is set, stay in IDLE.
  - Otherwise grant g = the first set bit searching from `rr_ptr` upward, wrapping at NUM_REQ-1 → 0.
  - On that edge: `req_ready_out[g]`←1, `cache_addr_out`←address of g, `cache_addr_valid_out`←1, `owner_out`←g, `busy_out`←1, counter←0, state←WAIT.
- WAIT:
  - `req_ready_out` and `cache_addr_valid_out` return to 0 after their single cycle. `cache_addr_out` holds its value.
  - `cache_valid_in`=1: `resp_data_out`←`cache_val_in`, `resp_valid_out[owner]`←1, `resp_err_out`←0, `rr_ptr`←(owner+1) mod NUM_REQ, `busy_out`←0, state←IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 and `cache_valid_in`=0: `resp_valid_out[owner]`←1, `resp_err_out`←1, `resp_data_out`←0, `rr_ptr` advances, state←IDLE.
  - If `cache_valid_in` and the timeout fall on the same cycle, the valid response wins (err=0).
- `resp_valid_out` and `resp_err_out` clear the cycle after their pulse. `resp_data_out` holds its value until the next response.
- `cache_valid_in` seen in IDLE is ignored: this covers stray responses and late responses after a timeout or reset.
- `req_valid_in` is not sampled in WAIT, so there is no double grant. Requesters deassert after seeing ready.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`; the counter never wraps.
- Reset in WAIT abandons the transaction; no response is generated for it.

## Timing
- Edge E0 (IDLE, request present): grant. During cycle E0→E1, `req_ready_out[g]` and `cache_addr_valid_out` are high.
- Cache samples the address at E1. If `cache_valid_in` is high in cycle k, the response pulse is visible in the cycle after edge k, and the state is IDLE at that same point.
- The next grant happens at the edge following the response cycle. Per-transaction occupancy is cache latency + 2 cycles.
- Timeout: the error pulse appears TIMEOUT_CYCLES cycles after the `cache_addr_valid_out` pulse.
- Fairness: under continuous requests from all requesters, each waits at most NUM_REQ-1 transactions.

## Test plan
- Requester 2 only, addr 0x0000_1234; cache returns 0xDEADBEEF 3 cycles after the address pulse → `req_ready_out`=4'b0100 for 1 cycle; `cache_addr_out`=0x1234 with a 1-cycle valid; `resp_valid_out`=4'b0100 with data 0xDEADBEEF and err=0.
- All 4 requesters held active, cache latency 2 → grant order 0,1,2,3,0,1; exactly one `req_ready_out` bit per transaction; `resp_valid_out` bits match.
- TIMEOUT_CYCLES=16, cache silent → `resp_err_out`=1 with `resp_valid_out[owner]` and data 0 exactly 16 cycles after the address pulse. A following request from requester 1 completes normally.
- `cache_valid_in` pulsed with 0xCAFE while IDLE → no `resp_valid_out`, no state change. The same pulse landing on the timeout cycle → data 0xCAFE, err=0.
- `rst_n_in` dropped mid-WAIT (no clock edge) → all outputs 0 immediately. After release, requests 3 and 0 together → 0 granted first (`rr_ptr`=0). A late cache response during IDLE is ignored.
